// File: rtl/feed_scheduler_if.sv
// rtl/feed_scheduler_if.sv - control/feeder bundle between top-level control and feed_scheduler
interface feed_scheduler_if #(
  parameter int N     = 7,
  parameter int DEPTH = 7
) ();
  localparam int CW = $clog2(DEPTH + N);

  logic          start;
  logic          abort;
  logic          feeder_load;
  logic [N-1:0]  feeder_en;
  logic          mac_clear;
  logic          busy;
  logic          done;
  logic [CW-1:0] feed_cycle;

  // Top-level control side: issues start/abort, observes the schedule.
  modport master (
    output start, abort,
    input  feeder_load, feeder_en, mac_clear, busy, done, feed_cycle
  );

  // Scheduler side.
  modport slave (
    input  start, abort,
    output feeder_load, feeder_en, mac_clear, busy, done, feed_cycle
  );
endinterface

// File: rtl/feed_scheduler.sv
// rtl/feed_scheduler.sv - load/skewed-feed/drain sequencer for the systolic MAC array feeders
module feed_scheduler #(
  parameter int N         = 7,
  parameter int DEPTH     = 7,
  parameter int DRAIN_CYC = 12
) (
  input logic            clk,
  input logic            reset,
  feed_scheduler_if.slave bus
);
  localparam int CW = $clog2(DEPTH + N);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  // Last skew count in FEED: row N-1 finishes its DEPTH enables here.
  localparam logic [CW-1:0] T_LAST = CW'(DEPTH + N - 2);
  // Last drain count; unused when the drain phase is skipped.
  localparam logic [DW-1:0] D_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] t_cnt;
  logic [DW-1:0] d_cnt;
  logic          in_feed;

  // Sequence state and counters; abort from any active state lands in IDLE
  // with counters cleared so every output decodes to 0 on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      t_cnt <= '0;
      d_cnt <= '0;
    end else if (bus.abort && (state != S_IDLE)) begin
      state <= S_IDLE;
      t_cnt <= '0;
      d_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= S_FEED;
          t_cnt <= '0;
        end
        S_FEED: begin
          if (t_cnt == T_LAST) begin
            t_cnt <= '0;
            d_cnt <= '0;
            state <= (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
          end else begin
            t_cnt <= t_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (d_cnt == D_LAST) begin
            d_cnt <= '0;
            state <= S_DONE;
          end else begin
            d_cnt <= d_cnt + DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          t_cnt <= '0;
          d_cnt <= '0;
        end
      endcase
    end
  end

  // Moore output decode: row i is enabled for the DEPTH skew counts starting at i.
  always_comb begin
    in_feed         = (state == S_FEED);
    bus.feeder_load = (state == S_LOAD);
    bus.mac_clear   = (state == S_LOAD);
    bus.busy        = (state == S_LOAD) || (state == S_FEED) || (state == S_DRAIN);
    bus.done        = (state == S_DONE);
    bus.feed_cycle  = in_feed ? t_cnt : '0;
    bus.feeder_en   = '0;
    for (int i = 0; i < N; i++) begin
      bus.feeder_en[i] = in_feed && (int'(t_cnt) >= i) && (int'(t_cnt) < i + DEPTH);
    end
  end
endmodule

// File: tb/tb_feed_scheduler.sv
// tb/tb_feed_scheduler.sv - scoreboard bench for feed_scheduler at default and N=1 parameters
module tb_feed_scheduler;
  localparam int NA = 7, DA = 7, RA = 12;
  localparam int NB = 1, DB = 3, RB = 0;

  typedef struct packed {
    logic       load;
    logic       mac;
    logic       busy;
    logic       done;
    logic [7:0] en;
    logic [3:0] fc;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  int   tests, fails, cyc;
  int   ka, kb;
  exp_t qa[$];
  exp_t qb[$];
  logic [55:0] feeder_sr;
  logic [7:0]  bytes_out[$];

  feed_scheduler_if #(.N(NA), .DEPTH(DA)) ifa ();
  feed_scheduler_if #(.N(NB), .DEPTH(DB)) ifb ();

  feed_scheduler #(.N(NA), .DEPTH(DA), .DRAIN_CYC(RA)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave)
  );
  feed_scheduler #(.N(NB), .DEPTH(DB), .DRAIN_CYC(RB)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k cycles after the start edge (k<1 means idle).
  function automatic exp_t model_out(int k, int n, int d, int dr);
    exp_t e;
    int   last, t;
    e    = '0;
    last = d + n + dr + 1;
    if (k == 1) begin
      e.load = 1'b1;
      e.mac  = 1'b1;
    end
    if (k >= 1 && k < last) e.busy = 1'b1;
    if (k == last) e.done = 1'b1;
    if (k >= 2 && k <= d + n) begin
      t    = k - 2;
      e.fc = 4'(t);
      for (int i = 0; i < n; i++) e.en[i] = (t >= i) && (t < i + d);
    end
    return e;
  endfunction

  function automatic int model_next(int k, logic s, logic a, logic r, int last);
    if (r) return -1;
    if (k >= 1) begin
      if (a || k == last) return -1;
      return k + 1;
    end
    if (s && !a) return 1;
    return -1;
  endfunction

  task automatic drive(input logic s, input logic a, input logic r);
    logic sb, ab, rb;
    @(negedge clk);
    sb = ($urandom_range(0, 2) == 0);
    ab = ($urandom_range(0, 29) == 0);
    rb = (cyc < 2) || ($urandom_range(0, 199) == 0);
    ifa.start = s; ifa.abort = a; rst_a = r;
    ifb.start = sb; ifb.abort = ab; rst_b = rb;
    ka = model_next(ka, s, a, r, DA + NA + RA + 1);
    kb = model_next(kb, sb, ab, rb, DB + NB + RB + 1);
    qa.push_back(model_out(ka, NA, DA, RA));
    qb.push_back(model_out(kb, NB, DB, RB));
    cyc++;
  endtask

  // Scoreboard monitor: one expected record per cycle per DUT.
  always @(posedge clk) begin
    exp_t e, act;
    #1;
    if (qa.size() > 0) begin
      e   = qa.pop_front();
      act = {ifa.feeder_load, ifa.mac_clear, ifa.busy, ifa.done,
             8'(ifa.feeder_en), 4'(ifa.feed_cycle)};
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL dut_a_outputs t=%0t got %h expected %h", $time, act, e);
      end
    end
    if (qb.size() > 0) begin
      e   = qb.pop_front();
      act = {ifb.feeder_load, ifb.mac_clear, ifb.busy, ifb.done,
             8'(ifb.feeder_en), 4'(ifb.feed_cycle)};
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL dut_b_outputs t=%0t got %h expected %h", $time, act, e);
      end
    end
  end

  // Behavioural model of the last row's byte-serial feeder.
  always @(negedge clk) begin
    if (ifa.feeder_load) begin
      feeder_sr = 56'h11223344556677;
    end else if (ifa.feeder_en[NA-1]) begin
      bytes_out.push_back(feeder_sr[55:48]);
      feeder_sr = {feeder_sr[47:0], 8'h00};
    end
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; ka = -1; kb = -1;
    feeder_sr = '0;
    ifa.start = 1'b0; ifa.abort = 1'b0; rst_a = 1'b1;
    ifb.start = 1'b0; ifb.abort = 1'b0; rst_b = 1'b1;

    repeat (2) drive(0, 0, 1);
    repeat (5) drive(0, 0, 0);

    bytes_out.delete();
    drive(1, 0, 0);
    repeat (35) drive(0, 0, 0);
    tests++;
    if (bytes_out.size() != DA) begin
      fails++;
      $display("FAIL feeder_byte_count got %0d expected %0d", bytes_out.size(), DA);
    end else begin
      for (int i = 0; i < DA; i++) begin
        tests++;
        if (bytes_out[i] !== 8'((i + 1) * 8'h11)) begin
          fails++;
          $display("FAIL feeder_byte[%0d] got %h expected %h", i, bytes_out[i], 8'((i + 1) * 8'h11));
        end
      end
    end

    repeat (60) drive(1, 0, 0);
    repeat (30) drive(0, 0, 0);

    drive(1, 0, 0);
    repeat (5) drive(0, 0, 0);
    drive(0, 1, 0);
    repeat (40) drive(0, 0, 0);

    drive(1, 0, 0);
    repeat (25) drive(1'($urandom_range(0, 1)), 0, 0);
    repeat (30) drive(0, 0, 0);

    drive(1, 0, 0);
    repeat (4) drive(0, 0, 0);
    drive(0, 0, 1);
    drive(1, 0, 0);
    repeat (30) drive(0, 0, 0);

    repeat (700) drive($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                       $urandom_range(0, 149) == 0);

    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
